// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : mem_access_unit_pkg                                   |
// | Purpose  : Shared types and defaults for the MEM-stage data port. |
// |            Holds the FSM state enum and the default data width   |
// |            and watchdog limit.                                   |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    MA_IDLE = 2'd0,
    MA_BUSY = 2'd1,
    MA_HOLD = 2'd2
  } mem_acc_state_t;

  localparam int DEFAULT_WIDTH   = 32;
  localparam int DEFAULT_TIMEOUT = 256;

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : mem_access_unit_if                                    |
// | Purpose  : Data-cache request/response bus.                       |
// | Ports    : master - request side (MEM stage) drives dmem_read,    |
// |            dmem_write, dmem_address, dmem_wdata, dmem_mbe and     |
// |            receives dmem_rdata, dmem_resp.                       |
// |            slave  - dcache side, the mirror image.               |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
interface mem_access_unit_if #(
  parameter int WIDTH = 32
);
  logic             dmem_read;
  logic             dmem_write;
  logic [WIDTH-1:0] dmem_address;
  logic [WIDTH-1:0] dmem_wdata;
  logic [3:0]       dmem_mbe;
  logic [WIDTH-1:0] dmem_rdata;
  logic             dmem_resp;

  modport master (
    output dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_mbe,
    input  dmem_rdata, dmem_resp
  );

  modport slave (
    input  dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_mbe,
    output dmem_rdata, dmem_resp
  );
endinterface
`default_nettype wire

// File: rtl/mem_access_unit_mem_req_reg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : mem_req_reg                                           |
// | Purpose  : Request register for the dcache port. Captures the     |
// |            address, store data, byte enables and read/write       |
// |            strobes on load; drop clears only the strobes so the   |
// |            last address/data stay visible.                       |
// | Ports    : clk, rst (async, active-low), load, drop,              |
// |            rd_in/wr_in/addr_in/wdata_in/mbe_in -> rd/wr/addr/     |
// |            wdata/mbe                                             |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module mem_req_reg #(
  parameter int WIDTH = 32
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             load,
  input  wire logic             drop,
  input  wire logic             rd_in,
  input  wire logic             wr_in,
  input  wire logic [WIDTH-1:0] addr_in,
  input  wire logic [WIDTH-1:0] wdata_in,
  input  wire logic [3:0]       mbe_in,
  output logic                  rd,
  output logic                  wr,
  output logic [WIDTH-1:0]      addr,
  output logic [WIDTH-1:0]      wdata,
  output logic [3:0]            mbe
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd    <= 1'b0;
      wr    <= 1'b0;
      addr  <= '0;
      wdata <= '0;
      mbe   <= '0;
    end else if (load) begin
      rd    <= rd_in;
      wr    <= wr_in;
      addr  <= addr_in;
      wdata <= wdata_in;
      mbe   <= mbe_in;
    end else if (drop) begin
      rd <= 1'b0;
      wr <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : mem_access_unit                                       |
// | Purpose  : MEM-stage data-memory port. Issues one registered      |
// |            dcache request per MEM instruction, holds it until     |
// |            dmem_resp, returns load data, stalls the pipe while    |
// |            the access is outstanding and never re-issues a        |
// |            completed access while the pipe is frozen.            |
// | Ports    : clk, rst (async, active-low)                           |
// |            req_read/req_write/req_addr/req_wdata/req_mbe - MEM op |
// |            bypass_en/bypass_data - serve load from MEM/WB data    |
// |            pipe_frozen - another stage holds the pipe             |
// |            dmem  - dcache bus (master modport)                    |
// |            mem_rdata, stall_mem, timeout_err (sticky)             |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             req_read,
  input  wire logic             req_write,
  input  wire logic [WIDTH-1:0] req_addr,
  input  wire logic [WIDTH-1:0] req_wdata,
  input  wire logic [3:0]       req_mbe,
  input  wire logic             bypass_en,
  input  wire logic [WIDTH-1:0] bypass_data,
  input  wire logic             pipe_frozen,
  mem_access_unit_if.master     dmem,
  output logic [WIDTH-1:0]      mem_rdata,
  output logic                  stall_mem,
  output logic                  timeout_err
);

  mem_acc_state_t   r_state;
  mem_acc_state_t   w_next_state;
  logic [WIDTH-1:0] r_rdata_q;
  logic             w_load;
  logic             w_drop;
  logic             w_rdata_en;

  // A simultaneous load+store is illegal; the load wins.
  wire logic w_issue_rd = req_read;
  wire logic w_issue_wr = req_write & ~req_read;

  mem_req_reg #(.WIDTH(WIDTH)) u_req_reg (
    .clk      (clk),
    .rst      (rst),
    .load     (w_load),
    .drop     (w_drop),
    .rd_in    (w_issue_rd),
    .wr_in    (w_issue_wr),
    .addr_in  (req_addr),
    .wdata_in (req_wdata),
    .mbe_in   (req_mbe),
    .rd       (dmem.dmem_read),
    .wr       (dmem.dmem_write),
    .addr     (dmem.dmem_address),
    .wdata    (dmem.dmem_wdata),
    .mbe      (dmem.dmem_mbe)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= MA_IDLE;
      r_rdata_q <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_rdata_en) r_rdata_q <= dmem.dmem_rdata;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_load       = 1'b0;
    w_drop       = 1'b0;
    w_rdata_en   = 1'b0;
    stall_mem    = 1'b0;
    mem_rdata    = r_rdata_q;
    unique case (r_state)
      MA_IDLE: begin
        if (req_read && bypass_en) begin
          // Forwarded from MEM/WB: no dcache access, no stall.
          mem_rdata = bypass_data;
        end else if (req_read || req_write) begin
          stall_mem    = 1'b1;
          w_load       = 1'b1;
          w_next_state = MA_BUSY;
        end
      end
      MA_BUSY: begin
        if (dmem.dmem_resp) begin
          mem_rdata    = dmem.dmem_rdata;
          w_rdata_en   = 1'b1;
          w_drop       = 1'b1;
          // If the pipe is still frozen the same instruction stays in MEM;
          // HOLD keeps it from being issued a second time.
          w_next_state = pipe_frozen ? MA_HOLD : MA_IDLE;
        end else begin
          stall_mem = 1'b1;
        end
      end
      MA_HOLD: begin
        if (!pipe_frozen) w_next_state = MA_IDLE;
      end
      default: w_next_state = MA_IDLE;
    endcase
  end

  generate
    if (TIMEOUT > 0) begin : g_watchdog
      localparam int CW = $clog2(TIMEOUT + 1);
      logic [CW-1:0] r_wd_cnt;

      // Counts unanswered BUSY cycles and saturates at TIMEOUT; the error
      // flag rises on the edge where the count reaches TIMEOUT and only
      // reset clears it.
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          r_wd_cnt    <= '0;
          timeout_err <= 1'b0;
        end else if (r_state != MA_BUSY) begin
          r_wd_cnt <= '0;
        end else if (!dmem.dmem_resp && (r_wd_cnt != CW'(TIMEOUT))) begin
          r_wd_cnt <= r_wd_cnt + 1'b1;
          if (r_wd_cnt == CW'(TIMEOUT - 1)) timeout_err <= 1'b1;
        end
      end
    end else begin : g_no_watchdog
      assign timeout_err = 1'b0;
    end
  endgenerate

  a_no_rd_wr : assert property (@(posedge clk) disable iff (!rst)
      !((r_state == MA_IDLE) && req_read && req_write))
    else $error("mem_access_unit: load and store requested together");

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | Module   : tb_mem_access_unit                                    |
// | Purpose  : Self-checking bench for mem_access_unit: directed      |
// |            accesses plus a transaction-level reference model.     |
// | Revision : 1.0 - initial release                                 |
// +------------------------------------------------------------------+
module tb_mem_access_unit;

  localparam int W   = 32;
  localparam int TMO = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_read = 1'b0, req_write = 1'b0, bypass_en = 1'b0, pipe_frozen = 1'b0;
  logic [W-1:0]  req_addr = '0, req_wdata = '0, bypass_data = '0;
  logic [3:0]    req_mbe = '0;
  logic [W-1:0]  mem_rdata;
  logic          stall_mem, timeout_err;

  mem_access_unit_if #(.WIDTH(W)) dmem_bus ();

  mem_access_unit #(.WIDTH(W), .TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_read    (req_read),
    .req_write   (req_write),
    .req_addr    (req_addr),
    .req_wdata   (req_wdata),
    .req_mbe     (req_mbe),
    .bypass_en   (bypass_en),
    .bypass_data (bypass_data),
    .pipe_frozen (pipe_frozen),
    .dmem        (dmem_bus.master),
    .mem_rdata   (mem_rdata),
    .stall_mem   (stall_mem),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int rd_txn  = 0;
  logic prev_rd = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // ---------------- reference model (transaction level) ----------------
  bit          m_out, m_wr, m_hold, m_to;
  int          m_cyc;
  logic [31:0] m_addr, m_wdata, m_last;
  logic [3:0]  m_mbe;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_out = 0; m_wr = 0; m_hold = 0; m_to = 0; m_cyc = 0;
      m_addr = '0; m_wdata = '0; m_mbe = '0; m_last = '0;
    end else if (m_out) begin
      if (dmem_bus.dmem_resp) begin
        m_out = 0; m_last = dmem_bus.dmem_rdata; m_hold = pipe_frozen; m_cyc = 0;
      end else begin
        m_cyc++;
        if (m_cyc == TMO) m_to = 1;
      end
    end else if (m_hold) begin
      if (!pipe_frozen) m_hold = 0;
    end else if ((req_read && !bypass_en) || req_write) begin
      m_out = 1; m_wr = !req_read; m_cyc = 0;
      m_addr = req_addr; m_wdata = req_wdata; m_mbe = req_mbe;
    end
  end

  // ---------------- single compare process ----------------
  always @(negedge clk) begin
    logic [31:0] e_rdata;
    bit          e_stall, rd_chk;
    e_rdata = m_last; rd_chk = 1;
    if (m_out) begin
      e_stall = !dmem_bus.dmem_resp;
      if (dmem_bus.dmem_resp && !m_wr) e_rdata = dmem_bus.dmem_rdata;
      else rd_chk = 0;
    end else if (m_hold) begin
      e_stall = 0;
    end else begin
      e_stall = (req_read && !bypass_en) || req_write;
      if (req_read && bypass_en) e_rdata = bypass_data;
    end
    check("dmem_read",    32'(dmem_bus.dmem_read),  32'(m_out && !m_wr));
    check("dmem_write",   32'(dmem_bus.dmem_write), 32'(m_out && m_wr));
    check("dmem_address", dmem_bus.dmem_address, m_addr);
    check("dmem_wdata",   dmem_bus.dmem_wdata, m_wdata);
    check("dmem_mbe",     32'(dmem_bus.dmem_mbe), 32'(m_mbe));
    check("stall_mem",    32'(stall_mem), 32'(e_stall));
    check("timeout_err",  32'(timeout_err), 32'(m_to));
    if (rd_chk) check("mem_rdata", mem_rdata, e_rdata);
    if (dmem_bus.dmem_read && !prev_rd) rd_txn++;
    prev_rd = dmem_bus.dmem_read;
  end

  // ---------------- directed access driver ----------------
  // Called #1 after a rising edge. Cycle 0 presents the op in IDLE; the
  // response arrives in BUSY cycle 'lat'; with frz>0 the pipe stays frozen
  // through the response and frz HOLD cycles, then releases.
  task automatic run_access(input bit rd, input bit wr, input bit bp,
                            input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] mbe, input logic [31:0] data,
                            input int lat, input int frz,
                            output int rd_cyc, output int wr_cyc,
                            output int st_cyc, output logic [31:0] got);
    rd_cyc = 0; wr_cyc = 0; st_cyc = 0; got = '0;
    req_read = rd; req_write = wr; bypass_en = bp; bypass_data = data;
    req_addr = addr; req_wdata = wdata; req_mbe = mbe; pipe_frozen = 0;
    @(negedge clk);
    rd_cyc += int'(dmem_bus.dmem_read); wr_cyc += int'(dmem_bus.dmem_write);
    st_cyc += int'(stall_mem);
    if (bp) got = mem_rdata;
    @(posedge clk); #1;
    if (!bp) begin
      for (int c = 1; c <= lat; c++) begin
        if (c == lat) begin
          dmem_bus.dmem_resp = 1'b1; dmem_bus.dmem_rdata = data; pipe_frozen = (frz > 0);
        end
        @(negedge clk);
        rd_cyc += int'(dmem_bus.dmem_read); wr_cyc += int'(dmem_bus.dmem_write);
        st_cyc += int'(stall_mem);
        check("addr_stable", dmem_bus.dmem_address, addr);
        check("mbe_stable", 32'(dmem_bus.dmem_mbe), 32'(mbe));
        if (c == lat) got = mem_rdata;
        @(posedge clk); #1;
        dmem_bus.dmem_resp = 1'b0; dmem_bus.dmem_rdata = '0;
      end
      if (frz > 0) begin
        for (int f = 0; f <= frz; f++) begin
          pipe_frozen = (f < frz);
          @(negedge clk);
          rd_cyc += int'(dmem_bus.dmem_read); wr_cyc += int'(dmem_bus.dmem_write);
          st_cyc += int'(stall_mem);
          @(posedge clk); #1;
        end
      end
    end
    req_read = 0; req_write = 0; bypass_en = 0; pipe_frozen = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

  initial begin
    int rc, wc, sc, t0;
    logic [31:0] got;
    dmem_bus.dmem_resp = 1'b0; dmem_bus.dmem_rdata = '0;

    // Reset values
    @(negedge clk);
    check("rst_dmem_read", 32'(dmem_bus.dmem_read), 32'd0);
    check("rst_dmem_address", dmem_bus.dmem_address, 32'd0);
    check("rst_timeout", 32'(timeout_err), 32'd0);
    check("rst_mem_rdata", mem_rdata, 32'd0);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;

    // 1: load, response in third BUSY cycle
    t0 = rd_txn;
    run_access(1, 0, 0, 32'h40, 32'h0, 4'hF, 32'hDEADBEEF, 3, 0, rc, wc, sc, got);
    check("t1_rd_cycles", rc, 3);
    check("t1_stall_cycles", sc, 3);
    check("t1_rdata", got, 32'hDEADBEEF);
    check("t1_txn", rd_txn - t0, 1);

    // 2: store, response in first BUSY cycle
    t0 = rd_txn;
    run_access(0, 1, 0, 32'h100, 32'h0000ABCD, 4'b0011, 32'h0, 1, 0, rc, wc, sc, got);
    check("t2_wr_cycles", wc, 1);
    check("t2_rd_cycles", rc, 0);
    check("t2_stall_cycles", sc, 1);
    check("t2_no_read_txn", rd_txn - t0, 0);

    // 3: load served by bypass
    t0 = rd_txn;
    run_access(1, 0, 1, 32'h44, 32'h0, 4'hF, 32'h12345678, 1, 0, rc, wc, sc, got);
    check("t3_stall", sc, 0);
    check("t3_rdata", got, 32'h12345678);
    check("t3_rd_cycles", rc, 0);
    @(negedge clk); check("t3_no_txn", rd_txn - t0, 0); @(posedge clk); #1;

    // 4: load completes while the pipe stays frozen for four more cycles
    t0 = rd_txn;
    run_access(1, 0, 0, 32'h48, 32'h0, 4'hF, 32'hCAFEF00D, 2, 4, rc, wc, sc, got);
    check("t4_rdata", got, 32'hCAFEF00D);
    check("t4_txn", rd_txn - t0, 1);
    check("t4_rd_cycles", rc, 2);
    check("t4_stall_cycles", sc, 2);
    @(negedge clk); check("t4_idle_rdata_q", mem_rdata, 32'hCAFEF00D); @(posedge clk); #1;

    // Back-to-back loads
    t0 = rd_txn;
    run_access(1, 0, 0, 32'h50, 32'h0, 4'hF, 32'h11111111, 1, 0, rc, wc, sc, got);
    check("b2b_a", got, 32'h11111111);
    run_access(1, 0, 0, 32'h54, 32'h0, 4'hF, 32'h22222222, 1, 0, rc, wc, sc, got);
    check("b2b_b", got, 32'h22222222);
    check("b2b_stall_cycles", sc, 1);
    check("b2b_txn", rd_txn - t0, 2);

    // 5: asynchronous reset in BUSY
    req_read = 1; req_addr = 32'h200; req_mbe = 4'hF;
    @(posedge clk); #1;
    @(negedge clk); check("t5_busy_read", 32'(dmem_bus.dmem_read), 32'd1);
    @(posedge clk); #2; rst = 1'b0; #1;
    check("t5_async_read", 32'(dmem_bus.dmem_read), 32'd0);
    check("t5_async_addr", dmem_bus.dmem_address, 32'd0);
    req_read = 0;
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    run_access(1, 0, 0, 32'h204, 32'h0, 4'hF, 32'h0BADCAFE, 1, 0, rc, wc, sc, got);
    check("t5_after_rdata", got, 32'h0BADCAFE);
    check("t5_after_rd_cycles", rc, 1);

    // 6: watchdog with no response
    req_read = 1; req_addr = 32'h300; req_mbe = 4'hF;
    @(posedge clk); #1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k == 8) check("t6_not_yet", 32'(timeout_err), 32'd0);
      if (k == 9) check("t6_raised", 32'(timeout_err), 32'd1);
      if (k == 12) check("t6_sticky", 32'(timeout_err), 32'd1);
      @(posedge clk); #1;
    end
    req_read = 0;
    rst = 1'b0; #1;
    check("t6_reset_clears", 32'(timeout_err), 32'd0);
    @(posedge clk); #1; rst = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
